// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the CPU/VGA RAM arbiter slice.
package ram_arb_pkg;

  localparam int ADDR_W_DFLT = 15;
  localparam int DATA_W_DFLT = 8;
  localparam int STAT_W      = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU_RD,
    OWN_CPU_WR,
    OWN_VGA
  } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the arbiter; the slave view belongs to the arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_addr, mem_wren, mem_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_addr, mem_wren, mem_data
  );

endinterface

// File: rtl/ram_arb_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency; cleared by reset so in-flight reads are dropped.
module ram_arb_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: VGA priority, bounded CPU starvation, read data steered by owner tag.
// Optional build macro RAM_ARB_STATS_EN adds saturating stall / VGA-read counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int STARVE_MAX = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_arbiter_if.slave      bus
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu_stall,
  output logic [STAT_W-1:0] stat_vga_reads
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                             input logic       req,
                                             input logic       gnt);
    if (!req || gnt) return 4'd0;
    return (cnt == STARVE_LIM) ? cnt : cnt + 4'd1;
  endfunction

  logic [3:0]        starve_cnt;
  logic              force_cpu;
  logic              cpu_gnt;
  logic              vga_gnt;
  owner_e            owner_p0;
  owner_e            owner_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_data_p1;
  logic              mem_wren_p1;
  owner_e            tag_p2;
  logic              cpu_vld_p3;
  logic              vga_vld_p3;
  logic [DATA_W-1:0] cpu_rdata_p3;
  logic [DATA_W-1:0] vga_rdata_p3;

  // p0: combinational grant and owner of the slot being granted
  always_comb begin
    force_cpu = (starve_cnt == STARVE_LIM);
    cpu_gnt   = reset_n & bus.cpu_req & (force_cpu | ~bus.vga_req);
    vga_gnt   = reset_n & bus.vga_req & ~cpu_gnt;
    owner_p0  = OWN_NONE;
    if (cpu_gnt)      owner_p0 = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    else if (vga_gnt) owner_p0 = OWN_VGA;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) starve_cnt <= 4'd0;
    else          starve_cnt <= starve_next(starve_cnt, bus.cpu_req, cpu_gnt);
  end

  // p1: owner FSM and registered RAM command
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner_p1    <= OWN_NONE;
      mem_addr_p1 <= '0;
      mem_data_p1 <= '0;
      mem_wren_p1 <= 1'b0;
    end else begin
      owner_p1    <= owner_p0;
      mem_wren_p1 <= (owner_p0 == OWN_CPU_WR);
      case (owner_p0)
        OWN_CPU_RD: mem_addr_p1 <= bus.cpu_addr;
        OWN_CPU_WR: begin
          mem_addr_p1 <= bus.cpu_addr;
          mem_data_p1 <= bus.cpu_wdata;
        end
        OWN_VGA:    mem_addr_p1 <= bus.vga_addr;
        default:    ;
      endcase
    end
  end

  // p2: owner tag aligned with mem_q
  ram_arb_tag_pipe #(.DEPTH(RAM_LAT)) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (owner_p1),
    .tag_out (tag_p2)
  );

  // p3: capture mem_q into the owner's read port
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cpu_vld_p3   <= 1'b0;
      vga_vld_p3   <= 1'b0;
      cpu_rdata_p3 <= '0;
      vga_rdata_p3 <= '0;
    end else begin
      cpu_vld_p3 <= (tag_p2 == OWN_CPU_RD);
      vga_vld_p3 <= (tag_p2 == OWN_VGA);
      if (tag_p2 == OWN_CPU_RD) cpu_rdata_p3 <= bus.mem_q;
      if (tag_p2 == OWN_VGA)    vga_rdata_p3 <= bus.mem_q;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.mem_addr   = mem_addr_p1;
  assign bus.mem_data   = mem_data_p1;
  assign bus.mem_wren   = mem_wren_p1;
  assign bus.cpu_rvalid = cpu_vld_p3;
  assign bus.cpu_rdata  = cpu_rdata_p3;
  assign bus.vga_rvalid = vga_vld_p3;
  assign bus.vga_rdata  = vga_rdata_p3;

`ifdef RAM_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] vreads_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q  <= '0;
      vreads_q <= '0;
    end else begin
      stall_q  <= sat_inc(stall_q, bus.cpu_req & ~cpu_gnt);
      vreads_q <= sat_inc(vreads_q, vga_gnt);
    end
  end

  assign stat_cpu_stall = stall_q;
  assign stat_vga_reads = vreads_q;
`endif

endmodule
